pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Parametrised control pipeline for the 5-stage MIPS core: takes the decoded control bundle from
//  controller in ID and carries it through ID/EX, EX/MEM and MEM/WB with destination register and valid.
//  Detects load-use, branch and jump hazards and drives the stall, flush and forwarding selects that the datapath consumes.
// PARAMETERS
//  REG_AW  5   register-address width (rs/rt/rd)
//  CTRL_W  11  control bundle width, packed {RegWr,RegDst,ExtOp,ALUSrc,ALUctr[2:0],Branch,Jump,MemWr,MemtoReg}
//  CNT_W   16  width of the stall and flush performance counters
// PORTS
//  clk          in   1       core clock; all state updates on rising edge
//  rst          in   1       asynchronous, active-high reset
//  run          in   1       global enable; 0 freezes all state (no update, outputs held)
//  id_valid     in   1       ID holds a real instruction
//  id_ctrl      in   CTRL_W  control bundle from controller for the ID instruction
//  id_rtype     in   1       ID instruction is R-type (uses rt as a source)
//  id_rs        in   REG_AW  ID source register rs
//  id_rt        in   REG_AW  ID source register rt
//  id_rd        in   REG_AW  ID destination register rd
//  ex_br_taken  in   1       branch in EX resolved taken (Branch & Zero from the datapath)
//  stall_if     out  1       hold PC
//  stall_id     out  1       hold the IF/ID register
//  flush_id     out  1       load a bubble into IF/ID
//  ex_valid/mem_valid/wb_valid  out 1 each      stage-valid flags
//  ex_ctrl/mem_ctrl/wb_ctrl     out CTRL_W each stage control bundles (zero while the stage is invalid)
//  ex_rs, ex_rt                 out REG_AW each EX source registers
//  ex_dst/mem_dst/wb_dst        out REG_AW each stage destination (RegDst ? rd : rt)
//  fwd_a, fwd_b  out  2       ALU operand-A/B select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
//  stall_cnt     out  CNT_W   cycles with stall_if=1; saturates at all-ones
//  flush_cnt     out  CNT_W   cycles with flush_id=1; saturates at all-ones
// BEHAVIOUR
//  - Reset: all valids 0, bundles/dst/rs/rt 0, fwd 00, stall/flush 0, counters 0; takes effect immediately, mid-op too.
//  - Advance (run=1): ID->EX->MEM->WB each cycle; MEM->WB and EX->MEM never stall.
//  - A stage write is ineffective when dst==0: the RegWr bit is cleared as the bundle enters EX.
//  - uses_rt = id_rtype | Branch | MemWr. hazard(x) = x_valid & x.RegWr & x_dst!=0 & (x_dst==id_rs | (uses_rt & x_dst==id_rt)).
//  - Load-use: id_valid & hazard(EX) & ex.MemtoReg -> stall_if=stall_id=1; bubble (valid 0, bundle 0) enters EX; 1 cycle.
//  - Jump: id_valid & id_ctrl.Jump & no stall -> flush_id=1 for 1 cycle (1 bubble).
//  - Branch: ex_br_taken & ex_valid & ex.Branch -> flush_id=1 and EX next = bubble (2 bubbles);
//    takes priority over a simultaneous stall or jump; stall outputs are 0 that cycle.
//  - Priority: rst > run=0 > branch flush > stall > jump flush.
//  - Outputs stall_*/flush_id/fwd_* are combinational from the current register state and inputs.
//  - Counters increment by 1 per qualifying cycle only when run=1; they hold at 2^CNT_W-1.
// CONFIGURATION
//  `define PIPE_FORWARD_EN:
//    fwd_a/b: 01 if mem RegWr & mem_dst!=0 & mem_dst==ex_rs/rt; else 10 on the same match with wb; else 00 (MEM wins).
//    Only the load-use hazard stalls.
//  Without it:
//    fwd_a/b are tied to 00.
//    Any hazard(EX) or hazard(MEM) stalls (as load-use) until the producer reaches WB.
//    The register file writes before it reads, so WB never stalls.
// STRUCTURE
//  pipeline_defs.vh holds the shared constants:
//    CTRL_W, bundle bit indices (CTRL_REGWR ... CTRL_MEMTOREG) and FWD_RF/FWD_MEM/FWD_WB encodings.
//  Sub-module hazard_unit (combinational): computes stall/flush/fwd from the stage fields.
//  pipeline_ctrl keeps the stage registers and counters.
// TESTING
//  lw $2,0($1); add $3,$2,$4 -> 1 stall cycle, EX bubble, then fwd_a=01... no: fwd_a=10 (WB) for add; stall_cnt=1.
//  add $2,..; sub $5,$2,$2 -> FORWARD_EN: no stall, fwd_a=fwd_b=01; without: 2 stall cycles, fwd=00.
//  beq in EX with ex_br_taken=1 while lw-use stall pending -> flush_id=1, stall_if=0, EX bubble, flush_cnt+1.
//  j in ID -> flush_id=1 exactly one cycle; following ID instruction never reaches EX valid.
//  addiu $0,$0,5 then add $3,$0,$0 -> ex RegWr cleared, no stall, fwd=00.
//  rst pulsed mid-stream with all stages valid -> all valids 0 and counters 0 immediately, before the next clk edge.
//  run=0 for 3 cycles -> all stage registers and counters unchanged.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared constants for the 5-stage MIPS control pipeline.
//   - CTRL_BUNDLE_W and the bit positions inside the control bundle, packed as
//     {RegWr,RegDst,ExtOp,ALUSrc,ALUctr[2:0],Branch,Jump,MemWr,MemtoReg}
//   - forwarding-select encodings for the ALU operand muxes
//   - src_hazard(): true when a producer stage writes a register that the
//     ID instruction reads
// ----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam int CTRL_BUNDLE_W = 11;

    localparam int CTRL_REGWR     = 10;
    localparam int CTRL_REGDST    = 9;
    localparam int CTRL_EXTOP     = 8;
    localparam int CTRL_ALUSRC    = 7;
    localparam int CTRL_ALUCTR_HI = 6;
    localparam int CTRL_ALUCTR_LO = 4;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_JUMP      = 2;
    localparam int CTRL_MEMWR     = 1;
    localparam int CTRL_MEMTOREG  = 0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // A producer conflicts with ID when it really writes a non-zero register
    // that ID reads as rs, or as rt when ID actually uses rt.
    function automatic logic src_hazard(
        input logic valid,
        input logic regwr,
        input logic dst_nz,
        input logic hit_rs,
        input logic hit_rt,
        input logic uses_rt
    );
        return valid & regwr & dst_nz & (hit_rs | (uses_rt & hit_rt));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_unit.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl_hazard_unit (hazard unit of pipeline_ctrl), purely combinational.
//   Build option: `define PIPE_FORWARD_EN enables EX operand forwarding; then
//   only load-use stalls. Without it every EX/MEM producer hazard stalls and
//   the forwarding selects are tied to the register file.
// Ports
//   id_*        ID instruction fields (valid, type bits, rs, rt)
//   ex_*        EX stage valid, RegWr/Branch (MemtoReg, rs, rt with forwarding), dst
//   mem_*       MEM stage valid, RegWr, dst
//   wb_*        WB stage valid, RegWr, dst (forwarding build only)
//   ex_br_taken branch in EX resolved taken
//   stall       hold PC and IF/ID
//   flush_id    bubble into IF/ID
//   kill_ex     EX receives a bubble next cycle
//   fwd_a/fwd_b ALU operand selects
// ----------------------------------------------------------------------------
module pipeline_ctrl_hazard_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
)(
    input  logic              id_valid,
    input  logic              id_rtype,
    input  logic              id_branch,
    input  logic              id_memwr,
    input  logic              id_jump,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_valid,
    input  logic              ex_regwr,
    input  logic              ex_branch,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              mem_valid,
    input  logic              mem_regwr,
    input  logic [REG_AW-1:0] mem_dst,
`ifdef PIPE_FORWARD_EN
    input  logic              ex_memtoreg,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              wb_valid,
    input  logic              wb_regwr,
    input  logic [REG_AW-1:0] wb_dst,
`endif
    input  logic              ex_br_taken,
    output logic              stall,
    output logic              flush_id,
    output logic              kill_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    logic w_uses_rt;
    logic w_haz_ex;
    logic w_need_stall;
    logic w_branch;

`ifdef PIPE_FORWARD_EN
    // Stall decision: only a load in EX feeding ID must wait.
    always_comb begin
        w_uses_rt    = id_rtype | id_branch | id_memwr;
        w_haz_ex     = src_hazard(ex_valid, ex_regwr, ex_dst != {REG_AW{1'b0}},
                                  ex_dst == id_rs, ex_dst == id_rt, w_uses_rt);
        w_need_stall = id_valid & w_haz_ex & ex_memtoreg;
    end

    // Operand selects: the younger MEM result wins over WB.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_valid && mem_regwr && (mem_dst != {REG_AW{1'b0}}) && (mem_dst == ex_rs)) begin
            fwd_a = FWD_MEM;
        end else if (wb_valid && wb_regwr && (wb_dst != {REG_AW{1'b0}}) && (wb_dst == ex_rs)) begin
            fwd_a = FWD_WB;
        end else begin
            fwd_a = FWD_RF;
        end
        if (mem_valid && mem_regwr && (mem_dst != {REG_AW{1'b0}}) && (mem_dst == ex_rt)) begin
            fwd_b = FWD_MEM;
        end else if (wb_valid && wb_regwr && (wb_dst != {REG_AW{1'b0}}) && (wb_dst == ex_rt)) begin
            fwd_b = FWD_WB;
        end else begin
            fwd_b = FWD_RF;
        end
    end
`else
    logic w_haz_mem;

    // Stall decision: any EX or MEM producer blocks ID until it reaches WB;
    // WB is safe because the register file writes before it reads.
    always_comb begin
        w_uses_rt    = id_rtype | id_branch | id_memwr;
        w_haz_ex     = src_hazard(ex_valid, ex_regwr, ex_dst != {REG_AW{1'b0}},
                                  ex_dst == id_rs, ex_dst == id_rt, w_uses_rt);
        w_haz_mem    = src_hazard(mem_valid, mem_regwr, mem_dst != {REG_AW{1'b0}},
                                  mem_dst == id_rs, mem_dst == id_rt, w_uses_rt);
        w_need_stall = id_valid & (w_haz_ex | w_haz_mem);
    end

    // Operand selects: always the register file.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
    end
`endif

    // Priority resolution: taken branch > stall > jump.
    always_comb begin
        w_branch = ex_br_taken & ex_valid & ex_branch;
        stall    = w_need_stall & ~w_branch;
        flush_id = w_branch | (id_valid & id_jump & ~w_need_stall);
        kill_ex  = w_branch | w_need_stall;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_ctrl
//   Control pipeline of the 5-stage MIPS core. Carries the decoded control
//   bundle, destination register and valid through ID/EX, EX/MEM and MEM/WB,
//   and drives stall/flush/forwarding selects via the hazard unit.
//   Build option: `define PIPE_FORWARD_EN selects the forwarding variant.
// Ports
//   clk, rst               clock; asynchronous active-high reset
//   run                    global enable, 0 freezes every register
//   id_valid/id_ctrl/id_rtype/id_rs/id_rt/id_rd  ID instruction
//   ex_br_taken            branch in EX resolved taken
//   stall_if, stall_id     hold PC / IF/ID
//   flush_id               bubble into IF/ID
//   ex_/mem_/wb_ valid, ctrl, dst ; ex_rs, ex_rt   stage state
//   fwd_a, fwd_b           ALU operand selects
//   stall_cnt, flush_cnt   saturating event counters
// ----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CTRL_W = CTRL_BUNDLE_W,
    parameter int CNT_W  = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_rtype,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_br_taken,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_dst,
    output logic [REG_AW-1:0] mem_dst,
    output logic [REG_AW-1:0] wb_dst,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              r_ex_valid, r_mem_valid, r_wb_valid;
    logic [CTRL_W-1:0] r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
    logic [REG_AW-1:0] r_ex_rs, r_ex_rt;
    logic [REG_AW-1:0] r_ex_dst, r_mem_dst, r_wb_dst;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

    logic [REG_AW-1:0] w_id_dst;
    logic [CTRL_W-1:0] w_id_ctrl;
    logic              w_stall, w_flush, w_kill_ex;
    logic [1:0]        w_fwd_a, w_fwd_b;

    // ID destination select; a write to $0 is dropped by clearing RegWr here
    // so no later stage ever treats it as a producer.
    always_comb begin
        w_id_dst  = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
        w_id_ctrl = id_ctrl;
        if (w_id_dst == {REG_AW{1'b0}}) begin
            w_id_ctrl[CTRL_REGWR] = 1'b0;
        end else begin
            w_id_ctrl[CTRL_REGWR] = id_ctrl[CTRL_REGWR];
        end
    end

    pipeline_ctrl_hazard_unit #(
        .REG_AW(REG_AW)
    ) u_hazard_unit (
        .id_valid   (id_valid),
        .id_rtype   (id_rtype),
        .id_branch  (id_ctrl[CTRL_BRANCH]),
        .id_memwr   (id_ctrl[CTRL_MEMWR]),
        .id_jump    (id_ctrl[CTRL_JUMP]),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_valid   (r_ex_valid),
        .ex_regwr   (r_ex_ctrl[CTRL_REGWR]),
        .ex_branch  (r_ex_ctrl[CTRL_BRANCH]),
        .ex_dst     (r_ex_dst),
        .mem_valid  (r_mem_valid),
        .mem_regwr  (r_mem_ctrl[CTRL_REGWR]),
        .mem_dst    (r_mem_dst),
`ifdef PIPE_FORWARD_EN
        .ex_memtoreg(r_ex_ctrl[CTRL_MEMTOREG]),
        .ex_rs      (r_ex_rs),
        .ex_rt      (r_ex_rt),
        .wb_valid   (r_wb_valid),
        .wb_regwr   (r_wb_ctrl[CTRL_REGWR]),
        .wb_dst     (r_wb_dst),
`endif
        .ex_br_taken(ex_br_taken),
        .stall      (w_stall),
        .flush_id   (w_flush),
        .kill_ex    (w_kill_ex),
        .fwd_a      (w_fwd_a),
        .fwd_b      (w_fwd_b)
    );

    // Stage registers: ID->EX takes a bubble on stall or taken branch;
    // EX->MEM and MEM->WB always advance while run is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_ex_ctrl   <= {CTRL_W{1'b0}};
            r_ex_rs     <= {REG_AW{1'b0}};
            r_ex_rt     <= {REG_AW{1'b0}};
            r_ex_dst    <= {REG_AW{1'b0}};
            r_mem_valid <= 1'b0;
            r_mem_ctrl  <= {CTRL_W{1'b0}};
            r_mem_dst   <= {REG_AW{1'b0}};
            r_wb_valid  <= 1'b0;
            r_wb_ctrl   <= {CTRL_W{1'b0}};
            r_wb_dst    <= {REG_AW{1'b0}};
        end else if (run) begin
            if (id_valid && !w_kill_ex) begin
                r_ex_valid <= 1'b1;
                r_ex_ctrl  <= w_id_ctrl;
                r_ex_rs    <= id_rs;
                r_ex_rt    <= id_rt;
                r_ex_dst   <= w_id_dst;
            end else begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= {CTRL_W{1'b0}};
                r_ex_rs    <= {REG_AW{1'b0}};
                r_ex_rt    <= {REG_AW{1'b0}};
                r_ex_dst   <= {REG_AW{1'b0}};
            end
            r_mem_valid <= r_ex_valid;
            r_mem_ctrl  <= r_ex_ctrl;
            r_mem_dst   <= r_ex_dst;
            r_wb_valid  <= r_mem_valid;
            r_wb_ctrl   <= r_mem_ctrl;
            r_wb_dst    <= r_mem_dst;
        end else begin
            r_ex_valid  <= r_ex_valid;
            r_mem_valid <= r_mem_valid;
            r_wb_valid  <= r_wb_valid;
        end
    end

    // Saturating stall/flush counters, counting only while run is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else if (run) begin
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end else begin
            r_stall_cnt <= r_stall_cnt;
            r_flush_cnt <= r_flush_cnt;
        end
    end

    assign stall_if  = w_stall;
    assign stall_id  = w_stall;
    assign flush_id  = w_flush;
    assign fwd_a     = w_fwd_a;
    assign fwd_b     = w_fwd_b;
    assign ex_valid  = r_ex_valid;
    assign mem_valid = r_mem_valid;
    assign wb_valid  = r_wb_valid;
    assign ex_ctrl   = r_ex_ctrl;
    assign mem_ctrl  = r_mem_ctrl;
    assign wb_ctrl   = r_wb_ctrl;
    assign ex_rs     = r_ex_rs;
    assign ex_rt     = r_ex_rt;
    assign ex_dst    = r_ex_dst;
    assign mem_dst   = r_mem_dst;
    assign wb_dst    = r_wb_dst;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; expectations follow PIPE_FORWARD_EN.
module tb_pipeline_ctrl;

    localparam int REG_AW = 5;
    localparam int CTRL_W = 11;
    localparam int CNT_W  = 4;

    // Bundle {RegWr,RegDst,ExtOp,ALUSrc,ALUctr[2:0],Branch,Jump,MemWr,MemtoReg}
    localparam logic [10:0] C_LW    = 11'h5A1;
    localparam logic [10:0] C_ADD   = 11'h620;
    localparam logic [10:0] C_SUB   = 11'h660;
    localparam logic [10:0] C_LDBR  = 11'h5A9;
    localparam logic [10:0] C_J     = 11'h004;
    localparam logic [10:0] C_ADDIU = 11'h5A0;

    logic              clk = 1'b0;
    logic              rst, run, id_valid, id_rtype, ex_br_taken;
    logic [CTRL_W-1:0] id_ctrl;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              stall_if, stall_id, flush_id, ex_valid, mem_valid, wb_valid;
    logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic [1:0]        fwd_a, fwd_b;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipeline_ctrl #(.REG_AW(REG_AW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .run(run), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rtype(id_rtype), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_br_taken(ex_br_taken), .stall_if(stall_if), .stall_id(stall_id),
        .flush_id(flush_id), .ex_valid(ex_valid), .mem_valid(mem_valid),
        .wb_valid(wb_valid), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic a_v, input logic [10:0] a_ctrl, input logic a_rtype,
                         input logic [4:0] a_rs, input logic [4:0] a_rt, input logic [4:0] a_rd);
        id_valid = a_v;
        id_ctrl  = a_ctrl;
        id_rtype = a_rtype;
        id_rs    = a_rs;
        id_rt    = a_rt;
        id_rd    = a_rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 11'h000, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b1; ex_br_taken = 1'b0;
        idle();
        tick(); tick();
        mid();
        chk("rst_ex_valid",  32'(ex_valid),  32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_wb_valid",  32'(wb_valid),  32'd0);
        chk("rst_ex_ctrl",   32'(ex_ctrl),   32'd0);
        chk("rst_stall",     32'(stall_if),  32'd0);
        chk("rst_flush",     32'(flush_id),  32'd0);
        chk("rst_fwd_a",     32'(fwd_a),     32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        rst = 1'b0;

        // lw $2,0($1) ; add $3,$2,$4
        drive(1'b1, C_LW, 1'b0, 5'd1, 5'd2, 5'd0);
        mid();
        chk("lw_no_stall", 32'(stall_if), 32'd0);
        tick();
        drive(1'b1, C_ADD, 1'b1, 5'd2, 5'd4, 5'd3);
        mid();
        chk("lu_stall_if", 32'(stall_if), 32'd1);
        chk("lu_stall_id", 32'(stall_id), 32'd1);
        chk("lu_flush",    32'(flush_id), 32'd0);
        chk("lu_ex_dst",   32'(ex_dst),   32'd2);
        tick(); exp_stall++;
        mid();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_ctrl",  32'(ex_ctrl),  32'd0);
        chk("lu_mem_dst",      32'(mem_dst),  32'd2);
`ifdef PIPE_FORWARD_EN
        chk("lu_released", 32'(stall_if), 32'd0);
        tick();
        idle();
        mid();
        chk("lu_wb_dst", 32'(wb_dst), 32'd2);
        chk("lu_fwd_a",  32'(fwd_a),  32'd2);
`else
        chk("lu_mem_stall", 32'(stall_if), 32'd1);
        tick(); exp_stall++;
        mid();
        chk("lu_released", 32'(stall_if), 32'd0);
        tick();
        idle();
        mid();
        chk("lu_fwd_a", 32'(fwd_a), 32'd0);
`endif
        chk("lu_add_valid", 32'(ex_valid),  32'd1);
        chk("lu_add_dst",   32'(ex_dst),    32'd3);
        chk("lu_fwd_b",     32'(fwd_b),     32'd0);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        repeat (3) tick();

        // add $2,$1,$1 ; sub $5,$2,$2
        drive(1'b1, C_ADD, 1'b1, 5'd1, 5'd1, 5'd2);
        tick();
        drive(1'b1, C_SUB, 1'b1, 5'd2, 5'd2, 5'd5);
        mid();
`ifdef PIPE_FORWARD_EN
        chk("raw_no_stall", 32'(stall_if), 32'd0);
        tick();
        idle();
        mid();
        chk("raw_fwd_a", 32'(fwd_a), 32'd1);
        chk("raw_fwd_b", 32'(fwd_b), 32'd1);
`else
        chk("raw_stall_ex", 32'(stall_if), 32'd1);
        tick(); exp_stall++;
        mid();
        chk("raw_stall_mem", 32'(stall_if), 32'd1);
        tick(); exp_stall++;
        mid();
        chk("raw_wb_no_stall", 32'(stall_if), 32'd0);
        tick();
        idle();
        mid();
        chk("raw_fwd_a", 32'(fwd_a), 32'd0);
        chk("raw_fwd_b", 32'(fwd_b), 32'd0);
`endif
        chk("raw_ex_dst",    32'(ex_dst),    32'd5);
        chk("raw_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        repeat (3) tick();

        // load+branch in EX; taken branch overrides the pending load-use stall
        drive(1'b1, C_LDBR, 1'b0, 5'd1, 5'd6, 5'd0);
        mid();
        chk("br_pre_flush", 32'(flush_id), 32'd0);
        tick();
        drive(1'b1, C_ADD, 1'b1, 5'd6, 5'd7, 5'd8);
        mid();
        chk("br_untaken_stall", 32'(stall_if), 32'd1);
        ex_br_taken = 1'b1;
        #1;
        chk("br_flush",    32'(flush_id), 32'd1);
        chk("br_stall_if", 32'(stall_if), 32'd0);
        chk("br_stall_id", 32'(stall_id), 32'd0);
        tick(); exp_flush++;
        ex_br_taken = 1'b0;
        idle();
        mid();
        chk("br_ex_bubble",  32'(ex_valid),  32'd0);
        chk("br_ex_ctrl",    32'(ex_ctrl),   32'd0);
        chk("br_mem_valid",  32'(mem_valid), 32'd1);
        chk("br_flush_cnt",  32'(flush_cnt), 32'(exp_flush));
        chk("br_stall_cnt",  32'(stall_cnt), 32'(exp_stall));

        // j in ID: exactly one flush cycle
        tick();
        drive(1'b1, C_J, 1'b0, 5'd0, 5'd0, 5'd0);
        mid();
        chk("j_flush", 32'(flush_id), 32'd1);
        chk("j_stall", 32'(stall_if), 32'd0);
        tick(); exp_flush++;
        idle();
        mid();
        chk("j_flush_once", 32'(flush_id), 32'd0);
        chk("j_ex_ctrl",    32'(ex_ctrl),  32'(C_J));
        tick();
        mid();
        chk("j_next_invalid", 32'(ex_valid),  32'd0);
        chk("j_flush_cnt",    32'(flush_cnt), 32'(exp_flush));

        // addiu $0,$0,5 ; add $3,$0,$0
        drive(1'b1, C_ADDIU, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(1'b1, C_ADD, 1'b1, 5'd0, 5'd0, 5'd3);
        mid();
        chk("z_regwr_cleared", 32'(ex_ctrl),  32'h1A0);
        chk("z_no_stall",      32'(stall_if), 32'd0);
        tick();
        idle();
        mid();
        chk("z_ex_dst",   32'(ex_dst),   32'd3);
        chk("z_mem_ctrl", 32'(mem_ctrl), 32'h1A0);
        chk("z_fwd_a",    32'(fwd_a),    32'd0);
        chk("z_fwd_b",    32'(fwd_b),    32'd0);

        // fill all stages, then freeze with run=0 for 3 cycles
        drive(1'b1, C_ADD, 1'b1, 5'd1, 5'd1, 5'd10); tick();
        drive(1'b1, C_ADD, 1'b1, 5'd1, 5'd1, 5'd11); tick();
        drive(1'b1, C_ADD, 1'b1, 5'd1, 5'd1, 5'd12); tick();
        drive(1'b1, C_ADD, 1'b1, 5'd12, 5'd1, 5'd13);
        run = 1'b0;
        mid();
`ifdef PIPE_FORWARD_EN
        chk("frz_stall_comb", 32'(stall_if), 32'd0);
`else
        chk("frz_stall_comb", 32'(stall_if), 32'd1);
`endif
        repeat (3) tick();
        mid();
        chk("frz_ex_dst",    32'(ex_dst),    32'd12);
        chk("frz_mem_dst",   32'(mem_dst),   32'd11);
        chk("frz_wb_dst",    32'(wb_dst),    32'd10);
        chk("frz_wb_valid",  32'(wb_valid),  32'd1);
        chk("frz_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        chk("frz_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

        // asynchronous reset between edges
        run = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_ex_valid",  32'(ex_valid),  32'd0);
        chk("arst_mem_valid", 32'(mem_valid), 32'd0);
        chk("arst_wb_valid",  32'(wb_valid),  32'd0);
        chk("arst_ex_dst",    32'(ex_dst),    32'd0);
        chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("arst_flush_cnt", 32'(flush_cnt), 32'd0);
        tick();
        rst = 1'b0;

        // continuous jumps: flush counter saturates at 15
        drive(1'b1, C_J, 1'b0, 5'd0, 5'd0, 5'd0);
        mid();
        chk("sat_flush", 32'(flush_id), 32'd1);
        for (int i = 0; i < 14; i++) tick();
        mid();
        chk("sat_cnt_14", 32'(flush_cnt), 32'd14);
        for (int i = 0; i < 6; i++) tick();
        mid();
        chk("sat_cnt_max",   32'(flush_cnt), 32'd15);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
